// File: rtl/reg_bank_param_if.sv
// Bus bundle for reg_bank_param: write port, two read ports, clear control and debug read.
// The master drives requests and addresses; the slave (the register bank) returns data and status.
interface reg_bank_param_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;

  logic [ADDR_W-1:0] rd_addr1;
  logic [DATA_W-1:0] rd_data1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data2;

  logic              clear_req;
  logic              busy;
  logic              clear_done;

  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic              dbg_valid;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr1, rd_addr2, clear_req, dbg_req, dbg_addr,
    input  wr_ready, rd_data1, rd_data2, busy, clear_done, dbg_data, dbg_valid
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr1, rd_addr2, clear_req, dbg_req, dbg_addr,
    output wr_ready, rd_data1, rd_data2, busy, clear_done, dbg_data, dbg_valid
  );
endinterface

// File: rtl/reg_bank_param.sv
// Parametrised register file: two combinational read ports with optional write bypass,
// optional hardwired-zero r0, a one-register-per-cycle clear sweep and a registered debug read.
module reg_bank_param #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input logic              clk,
  input logic              reset,
  reg_bank_param_if.slave  bus
);

  localparam int unsigned       DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              clear_done_q, clear_done_d;

  logic              busy;
  logic              wr_fire;
  logic              wr_commit;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] dbg_data_q;
  logic              dbg_valid_q;
  logic [DATA_W-1:0] rd_data1, rd_data2;

  // Sequencer state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      clear_done_q <= clear_done_d;
    end
  end

  // Sequencer next state
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    clear_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.clear_req) begin
          state_d = StClear;
          ptr_d   = '0;
        end
      end
      StClear: begin
        // Terminal compare, so the pointer never relies on wrap-around
        if (ptr_q == LAST) begin
          state_d      = StIdle;
          ptr_d        = '0;
          clear_done_d = 1'b1;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        ptr_d   = '0;
      end
    endcase
  end

  // Sequencer outputs and write qualification
  always_comb begin
    busy      = (state_q == StClear);
    wr_fire   = bus.wr_en && !busy;
    wr_commit = wr_fire && !(ZERO_REG && (bus.wr_addr == '0));
  end

  // Storage: the sweep and the write port are mutually exclusive since busy blocks writes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q <= '{default: '0};
    end else if (busy) begin
      mem_q[ptr_q] <= '0;
    end else if (wr_commit) begin
      mem_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Read ports: zero register wins over bypass, bypass wins over storage
  always_comb begin
    rd_data1 = mem_q[bus.rd_addr1];
    if (ZERO_REG && (bus.rd_addr1 == '0)) begin
      rd_data1 = '0;
    end else if (BYPASS && wr_fire && (bus.wr_addr == bus.rd_addr1)) begin
      rd_data1 = bus.wr_data;
    end

    rd_data2 = mem_q[bus.rd_addr2];
    if (ZERO_REG && (bus.rd_addr2 == '0)) begin
      rd_data2 = '0;
    end else if (BYPASS && wr_fire && (bus.wr_addr == bus.rd_addr2)) begin
      rd_data2 = bus.wr_data;
    end
  end

  // Debug read samples pre-edge storage, so a write committing on the same edge is not seen
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dbg_data_q  <= '0;
      dbg_valid_q <= 1'b0;
    end else begin
      dbg_valid_q <= bus.dbg_req;
      if (bus.dbg_req) begin
        if (ZERO_REG && (bus.dbg_addr == '0)) begin
          dbg_data_q <= '0;
        end else begin
          dbg_data_q <= mem_q[bus.dbg_addr];
        end
      end
    end
  end

  assign bus.wr_ready   = !busy;
  assign bus.busy       = busy;
  assign bus.clear_done = clear_done_q;
  assign bus.rd_data1   = rd_data1;
  assign bus.rd_data2   = rd_data2;
  assign bus.dbg_data   = dbg_data_q;
  assign bus.dbg_valid  = dbg_valid_q;

endmodule

// File: tb/tb_reg_bank_param.sv
// Bench for reg_bank_param: a 32x32 bank with bypass, a mirrored copy without bypass,
// and a small 8x8 bank, checked against an array/countdown model plus literal expectations.
module tb_reg_bank_param;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  reg_bank_param_if #(.DATA_W(32), .ADDR_W(5)) bus0 ();
  reg_bank_param_if #(.DATA_W(32), .ADDR_W(5)) bus1 ();
  reg_bank_param_if #(.DATA_W(8),  .ADDR_W(3)) bus2 ();

  reg_bank_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave)
  );
  reg_bank_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave)
  );
  reg_bank_param #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut2 (
    .clk(clk), .reset(reset), .bus(bus2.slave)
  );

  // The no-bypass bank sees exactly the stimulus of the main bank
  assign bus1.wr_en     = bus0.wr_en;
  assign bus1.wr_addr   = bus0.wr_addr;
  assign bus1.wr_data   = bus0.wr_data;
  assign bus1.rd_addr1  = bus0.rd_addr1;
  assign bus1.rd_addr2  = bus0.rd_addr2;
  assign bus1.clear_req = bus0.clear_req;
  assign bus1.dbg_req   = bus0.dbg_req;
  assign bus1.dbg_addr  = bus0.dbg_addr;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: plain array plus a countdown of sweep cycles still to run
  logic [31:0] m_mem [32];
  int          m_left;
  logic        m_done;
  logic [31:0] m_dbg_data;
  logic        m_dbg_valid;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) m_mem[i] <= '0;
      m_left      <= 0;
      m_done      <= 1'b0;
      m_dbg_data  <= '0;
      m_dbg_valid <= 1'b0;
    end else begin
      m_dbg_valid <= bus0.dbg_req;
      if (bus0.dbg_req) m_dbg_data <= (bus0.dbg_addr == 5'd0) ? 32'd0 : m_mem[bus0.dbg_addr];
      if (m_left > 0) begin
        m_mem[5'(32 - m_left)] <= '0;
        m_left <= m_left - 1;
        m_done <= (m_left == 1);
      end else begin
        m_done <= 1'b0;
        if (bus0.wr_en && bus0.wr_addr != 5'd0) m_mem[bus0.wr_addr] <= bus0.wr_data;
        if (bus0.clear_req) m_left <= 32;
      end
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'd0;
    if (byp && bus0.wr_en && m_left == 0 && bus0.wr_addr == a) return bus0.wr_data;
    return m_mem[a];
  endfunction

  always @(negedge clk) begin
    chk("model_rd1_byp",   bus0.rd_data1,   exp_rd(bus0.rd_addr1, 1'b1));
    chk("model_rd2_byp",   bus0.rd_data2,   exp_rd(bus0.rd_addr2, 1'b1));
    chk("model_rd1_nobyp", bus1.rd_data1,   exp_rd(bus0.rd_addr1, 1'b0));
    chk("model_rd2_nobyp", bus1.rd_data2,   exp_rd(bus0.rd_addr2, 1'b0));
    chk("model_busy",      32'(bus0.busy),       32'(m_left > 0));
    chk("model_wr_ready",  32'(bus0.wr_ready),   32'(m_left == 0));
    chk("model_done",      32'(bus0.clear_done), 32'(m_done));
    chk("model_dbg_valid", 32'(bus0.dbg_valid),  32'(m_dbg_valid));
    chk("model_dbg_data",  bus0.dbg_data,        m_dbg_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus0.wr_en = 1'b0; bus0.wr_addr = '0; bus0.wr_data = '0;
    bus0.rd_addr1 = '0; bus0.rd_addr2 = '0;
    bus0.clear_req = 1'b0; bus0.dbg_req = 1'b0; bus0.dbg_addr = '0;
    bus2.wr_en = 1'b0; bus2.wr_addr = '0; bus2.wr_data = '0;
    bus2.rd_addr1 = '0; bus2.rd_addr2 = '0;
    bus2.clear_req = 1'b0; bus2.dbg_req = 1'b0; bus2.dbg_addr = '0;
  endtask

  int busy_cnt;
  int done_cnt;

  initial begin
    idle_in();
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state on every address
    @(negedge clk);
    chk("rst_busy", 32'(bus0.busy), 32'd0);
    chk("rst_dbg_valid", 32'(bus0.dbg_valid), 32'd0);
    for (int a = 0; a < 32; a++) begin
      tick();
      bus0.rd_addr1 = 5'(a);
      bus0.rd_addr2 = 5'(31 - a);
      @(negedge clk);
      chk("rst_rd1", bus0.rd_data1, 32'd0);
      chk("rst_rd2", bus0.rd_data2, 32'd0);
    end

    // Plain write then read on both ports
    tick();
    bus0.wr_en = 1'b1; bus0.wr_addr = 5'd5; bus0.wr_data = 32'hDEADBEEF;
    tick();
    bus0.wr_en = 1'b0; bus0.rd_addr1 = 5'd5; bus0.rd_addr2 = 5'd5;
    @(negedge clk);
    chk("r5_rd1", bus0.rd_data1, 32'hDEADBEEF);
    chk("r5_rd2", bus0.rd_data2, 32'hDEADBEEF);

    // Hardwired zero register, including bypass and debug
    tick();
    bus0.wr_en = 1'b1; bus0.wr_addr = 5'd0; bus0.wr_data = 32'h12345678; bus0.rd_addr1 = 5'd0;
    @(negedge clk);
    chk("r0_rd1_same", bus0.rd_data1, 32'd0);
    tick();
    bus0.wr_en = 1'b0;
    @(negedge clk);
    chk("r0_rd1_after", bus0.rd_data1, 32'd0);
    tick();
    bus0.dbg_req = 1'b1; bus0.dbg_addr = 5'd5;
    tick();
    bus0.dbg_addr = 5'd0;
    @(negedge clk);
    chk("dbg_r5_data", bus0.dbg_data, 32'hDEADBEEF);
    chk("dbg_r5_valid", 32'(bus0.dbg_valid), 32'd1);
    tick();
    bus0.dbg_req = 1'b0;
    @(negedge clk);
    chk("dbg_r0_data", bus0.dbg_data, 32'd0);
    chk("dbg_r0_valid", 32'(bus0.dbg_valid), 32'd1);
    tick();
    @(negedge clk);
    chk("dbg_idle_valid", 32'(bus0.dbg_valid), 32'd0);

    // Bypass versus no bypass
    tick();
    bus0.wr_en = 1'b1; bus0.wr_addr = 5'd7; bus0.wr_data = 32'hA5A5A5A5; bus0.rd_addr2 = 5'd7;
    @(negedge clk);
    chk("byp_rd2", bus0.rd_data2, 32'hA5A5A5A5);
    chk("nobyp_rd2", bus1.rd_data2, 32'd0);
    tick();
    bus0.wr_en = 1'b0;
    @(negedge clk);
    chk("nobyp_rd2_after", bus1.rd_data2, 32'hA5A5A5A5);

    // Fill r1..r31 with their index
    for (int i = 1; i < 32; i++) begin
      tick();
      bus0.wr_en = 1'b1; bus0.wr_addr = 5'(i); bus0.wr_data = 32'(i);
    end
    tick();
    bus0.wr_en = 1'b0; bus0.rd_addr1 = 5'd31; bus0.rd_addr2 = 5'd9;
    @(negedge clk);
    chk("fill_r31", bus0.rd_data1, 32'd31);
    chk("fill_r9", bus0.rd_data2, 32'd9);

    // Sweep with a write landing on the start edge and a write held during busy
    tick();
    bus0.clear_req = 1'b1;
    bus0.wr_en = 1'b1; bus0.wr_addr = 5'd3; bus0.wr_data = 32'h333;
    tick();
    bus0.clear_req = 1'b0;
    bus0.wr_addr = 5'd9; bus0.wr_data = 32'h99;
    busy_cnt = 0;
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0) chk("sweep_wr_ready", 32'(bus0.wr_ready), 32'd0);
      if (bus0.busy) busy_cnt++;
      if (bus0.clear_done) done_cnt++;
      tick();
      if (c == 20) bus0.wr_en = 1'b0;
    end
    chk("sweep_busy_cycles", 32'(busy_cnt), 32'd32);
    chk("sweep_done_pulses", 32'(done_cnt), 32'd1);
    for (int a = 0; a < 32; a++) begin
      bus0.rd_addr1 = 5'(a);
      bus0.rd_addr2 = 5'(a);
      @(negedge clk);
      chk("post_sweep_rd1", bus0.rd_data1, 32'd0);
      tick();
    end

    // Reset in the middle of a sweep
    bus0.wr_en = 1'b1; bus0.wr_addr = 5'd20; bus0.wr_data = 32'h55;
    tick();
    bus0.wr_en = 1'b0; bus0.clear_req = 1'b1; bus0.rd_addr1 = 5'd20;
    tick();
    bus0.clear_req = 1'b0;
    repeat (9) tick();
    @(negedge clk);
    chk("mid_sweep_r20", bus0.rd_data1, 32'h55);
    chk("mid_sweep_busy", 32'(bus0.busy), 32'd1);
    tick();
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(bus0.busy), 32'd0);
    chk("abort_r20", bus0.rd_data1, 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus0.clear_done) done_cnt++;
      tick();
    end
    chk("abort_no_done", 32'(done_cnt), 32'd0);

    // clear_req held high restarts a sweep right after each completion
    bus0.clear_req = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (bus0.clear_done) done_cnt++;
      tick();
    end
    bus0.clear_req = 1'b0;
    chk("held_done_pulses", 32'(done_cnt), 32'd2);
    repeat (40) tick();

    // Small 8x8 bank
    bus2.wr_en = 1'b1; bus2.wr_addr = 3'd7; bus2.wr_data = 8'hFF;
    tick();
    bus2.wr_en = 1'b0; bus2.rd_addr1 = 3'd7;
    @(negedge clk);
    chk("small_r7", 32'(bus2.rd_data1), 32'hFF);
    tick();
    bus2.clear_req = 1'b1;
    tick();
    bus2.clear_req = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus2.busy) busy_cnt++;
      if (bus2.clear_done) done_cnt++;
      tick();
    end
    chk("small_busy_cycles", 32'(busy_cnt), 32'd8);
    chk("small_done_pulses", 32'(done_cnt), 32'd1);
    @(negedge clk);
    chk("small_r7_cleared", 32'(bus2.rd_data1), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
